stc_sequencer: RTL and testbench
================================

Name: stc_sequencer

Overview:
Programmable gain-curve sequencer for the STC video gain datapath. It holds a table of 12-bit shift-control (gain) words loaded through a valid/ready config port. On each radar trigger it steps through the table at a programmable sample interval and presents the current gain word to the shift-and-add gain stage. After the last entry it holds the final gain until the next trigger.

Parameters:
ADDR_W, 6, table address width; table depth = 2**ADDR_W entries
GAIN_W, 12, gain/shift-control word width
DIV_W, 8, width of the sample-interval divider

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
trig  in  1  radar trigger, level input; run starts on rising edge (sampled synchronously)
div_val  in  DIV_W  clocks per table entry minus 1; latched on trigger edge
last_idx  in  ADDR_W  index of final table entry; latched on trigger edge
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accept
cfg_addr  in  ADDR_W  table write address
cfg_data  in  GAIN_W  table write data
gain_out  out  GAIN_W  current shift-control word to the gain datapath
busy  out  1  high while stepping (RUN)
done  out  1  one-cycle pulse on entry to HOLD

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at an edge): state=IDLE; idx=0; cnt=0; gain_out=0; busy=0; done=0; all table entries=0; trig edge-detect register=0; latched div/last=0. Reset mid-run aborts immediately; no done pulse.
- Trigger edge: trig_q registers trig; trig_edge = trig & ~trig_q. Holding trig high starts exactly one run.
- States: IDLE, RUN, HOLD.
  - IDLE: gain_out=0 (blanked). trig_edge -> RUN.
  - RUN: busy=1. cnt counts 0..div_lat. When cnt==div_lat: cnt<=0 and idx<=idx+1, unless idx==last_lat, in which case -> HOLD. Each entry is presented for exactly div_lat+1 clocks.
  - HOLD: busy=0; gain_out keeps table[last_lat]; done=1 for the first HOLD cycle only. trig_edge -> RUN.
- On trig_edge, from any state including RUN (restart): at the next edge, idx=0, cnt=0, div_lat<=div_val, last_lat<=last_idx, gain_out<=table[0], state=RUN. Latency from trig rising at edge T to gain_out=table[0] is 1 clock (visible after edge T+1). A restart from RUN produces no done pulse.
- gain_out is registered and loaded with table[next idx] on the same edge that idx changes, so gain_out always equals table[idx] during RUN. A table write never changes gain_out directly.
- Config: cfg_ready = (state!=RUN) & rst_n. A write occurs at an edge with cfg_valid & cfg_ready: table[cfg_addr]<=cfg_data. In RUN the write stalls; cfg_valid/addr/data must be held until accepted. A write on the same edge as trig_edge from IDLE/HOLD is accepted. Table read for table[0] on that edge returns the old value.
- Edge cases: div_val=0 gives one clock per entry. last_idx=0 runs a single entry. idx never wraps because the run stops at last_lat. div_val and last_idx changes mid-run have no effect.
- Widths: cnt DIV_W bits; idx ADDR_W bits; no arithmetic overflow possible.

Test Plan:
1. Reset: hold rst_n=0 for 2 clocks with cfg_valid=1 and trig=1 -> gain_out=0, busy=0, done=0, cfg_ready=0, no table write (subsequent run with last_idx=0 outputs 0).
2. Basic run: write table[0..3]=1,2,3,4; div_val=1, last_idx=3; trig rises at edge T -> gain_out on T+1..T+8 = 1,1,2,2,3,3,4,4; busy=1 on T+1..T+8; at T+9 busy=0, done=1 for one cycle, gain_out=4 held for 20+ cycles.
3. Level trigger and retrigger: hold trig high 30 cycles -> single run and single done. Drop trig, then raise it again at idx=2 mid-run -> gain_out returns to 1 one clock later, with no done pulse for the aborted run.
4. Config stall: assert cfg_valid (addr=1, data=12'hABC) during RUN -> cfg_ready=0 until HOLD. The write lands on the first HOLD edge, and gain_out stays 4. The next run shows 12'hABC at entry 1.
5. Minimal run: div_val=0, last_idx=0, table[0]=12'h800 -> gain_out=12'h800 for one RUN cycle, then HOLD with done pulse and gain_out=12'h800.
6. Reset mid-run: drop rst_n for 1 clock at idx=1 -> IDLE, gain_out=0, no done, table cleared (next run outputs 0).

Source files
------------

// File: rtl/stc_sequencer.sv
// STC gain-curve sequencer: steps a loadable gain table at a programmable
// sample interval after each radar trigger, then holds the final gain.
module stc_sequencer #(
    parameter int ADDR_W = 6,
    parameter int GAIN_W = 12,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic [DIV_W-1:0]  div_val,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [GAIN_W-1:0] cfg_data,
    output logic [GAIN_W-1:0] gain_out,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt, idx_inc;
    logic [ADDR_W-1:0] last_lat, last_nxt;
    logic [DIV_W-1:0]  cnt, cnt_nxt;
    logic [DIV_W-1:0]  div_lat, div_nxt;
    logic [GAIN_W-1:0] gain_nxt;
    logic              done_nxt;
    logic              trig_q;
    logic              trig_edge;
    logic              wr_en;
    logic [GAIN_W-1:0] gain_tab [DEPTH];

    assign trig_edge = trig & ~trig_q;
    assign cfg_ready = (state != RUN) & rst_n;
    assign wr_en     = cfg_valid & cfg_ready;
    assign busy      = (state == RUN);
    assign idx_inc   = idx + ADDR_W'(1);

    // Table writes stall during RUN, so the look-ahead read of the next entry stays coherent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                gain_tab[i] <= '0;
            end
        end else if (wr_en) begin
            gain_tab[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        div_nxt   = div_lat;
        last_nxt  = last_lat;
        gain_nxt  = gain_out;
        done_nxt  = 1'b0;
        if (trig_edge) begin
            // A trigger edge restarts from any state, including mid-run.
            state_nxt = RUN;
            idx_nxt   = '0;
            cnt_nxt   = '0;
            div_nxt   = div_val;
            last_nxt  = last_idx;
            gain_nxt  = gain_tab[0];
        end else begin
            case (state)
                IDLE: gain_nxt = '0;
                RUN: begin
                    if (cnt == div_lat) begin
                        cnt_nxt = '0;
                        if (idx == last_lat) begin
                            state_nxt = HOLD;
                            done_nxt  = 1'b1;
                        end else begin
                            idx_nxt  = idx_inc;
                            gain_nxt = gain_tab[idx_inc];
                        end
                    end else begin
                        cnt_nxt = cnt + DIV_W'(1);
                    end
                end
                HOLD: ;
                default: begin
                    state_nxt = IDLE;
                    gain_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            div_lat  <= '0;
            last_lat <= '0;
            gain_out <= '0;
            done     <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            div_lat  <= div_nxt;
            last_lat <= last_nxt;
            gain_out <= gain_nxt;
            done     <= done_nxt;
            trig_q   <= trig;
        end
    end

endmodule

// File: tb/tb_stc_sequencer.sv
// Directed bench for stc_sequencer: inputs driven and outputs checked on the
// falling edge, so every check reflects the preceding rising edge.
module tb_stc_sequencer;

    localparam int ADDR_W = 6;
    localparam int GAIN_W = 12;
    localparam int DIV_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              trig;
    logic [DIV_W-1:0]  div_val;
    logic [ADDR_W-1:0] last_idx;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [GAIN_W-1:0] cfg_data;
    logic [GAIN_W-1:0] gain_out;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    stc_sequencer #(.ADDR_W(ADDR_W), .GAIN_W(GAIN_W), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig),
        .div_val  (div_val),
        .last_idx (last_idx),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .gain_out (gain_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [GAIN_W-1:0] g, input logic b, input logic d);
        chk({tag, ".gain"}, 32'(gain_out), 32'(g));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [GAIN_W-1:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        // Reset with write request and trigger asserted
        rst_n = 1'b0; trig = 1'b1; cfg_valid = 1'b1; cfg_addr = '0; cfg_data = 12'h005;
        div_val = '0; last_idx = '0;
        tick(); tick();
        chk_out("reset", 12'h000, 1'b0, 1'b0);
        chk("reset.cfg_ready", 32'(cfg_ready), 32'd0);
        rst_n = 1'b1; trig = 1'b0; cfg_valid = 1'b0;
        tick();
        chk("idle.cfg_ready", 32'(cfg_ready), 32'd1);
        trig = 1'b1;
        tick();
        chk_out("rst_nowrite.run", 12'h000, 1'b1, 1'b0);
        tick();
        chk_out("rst_nowrite.hold", 12'h000, 1'b0, 1'b1);
        trig = 1'b0;

        // Basic run, trigger held high for 30 cycles
        wr(0, 12'd1); wr(1, 12'd2); wr(2, 12'd3); wr(3, 12'd4);
        div_val = 8'd1; last_idx = 6'd3;
        trig = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out($sformatf("basic[%0d]", i), GAIN_W'(i / 2 + 1), 1'b1, 1'b0);
        end
        tick();
        chk_out("basic.hold", 12'd4, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_out($sformatf("level_hold[%0d]", i), 12'd4, 1'b0, 1'b0);
        end

        // Retrigger mid-run at idx=2
        trig = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        chk_out("rt.start", 12'd1, 1'b1, 1'b0);
        trig = 1'b0;
        tick(); tick(); tick(); tick();
        chk_out("rt.idx2", 12'd3, 1'b1, 1'b0);
        trig = 1'b1;
        tick();
        chk_out("rt.restart", 12'd1, 1'b1, 1'b0);
        trig = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_out($sformatf("rt.run[%0d]", i), GAIN_W'(i / 2 + 1), 1'b1, 1'b0);
        end
        tick();
        chk_out("rt.hold", 12'd4, 1'b0, 1'b1);

        // Config write stalled during RUN
        trig = 1'b1;
        tick();
        trig = 1'b0;
        cfg_valid = 1'b1; cfg_addr = 6'd1; cfg_data = 12'hABC;
        chk("stall.ready0", 32'(cfg_ready), 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("stall.ready[%0d]", i), 32'(cfg_ready), 32'd0);
            chk($sformatf("stall.gain[%0d]", i), 32'(gain_out), 32'(i / 2 + 1));
        end
        tick();
        chk("stall.ready_hold", 32'(cfg_ready), 32'd1);
        chk_out("stall.hold", 12'd4, 1'b0, 1'b1);
        tick();
        cfg_valid = 1'b0;
        chk_out("stall.after_wr", 12'd4, 1'b0, 1'b0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk_out("abc.e0a", 12'd1, 1'b1, 1'b0);
        tick(); chk_out("abc.e0b", 12'd1, 1'b1, 1'b0);
        tick(); chk_out("abc.e1a", 12'hABC, 1'b1, 1'b0);
        tick(); chk_out("abc.e1b", 12'hABC, 1'b1, 1'b0);
        tick(); tick(); tick(); tick();
        chk_out("abc.e3b", 12'd4, 1'b1, 1'b0);
        tick();
        chk_out("abc.hold", 12'd4, 1'b0, 1'b1);

        // Minimal run: one entry, one clock
        wr(0, 12'h800);
        div_val = 8'd0; last_idx = 6'd0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk_out("min.run", 12'h800, 1'b1, 1'b0);
        tick(); chk_out("min.hold", 12'h800, 1'b0, 1'b1);
        tick(); chk_out("min.hold2", 12'h800, 1'b0, 1'b0);

        // Reset mid-run at idx=1
        div_val = 8'd1; last_idx = 6'd3;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk_out("mr.e0", 12'h800, 1'b1, 1'b0);
        tick(); tick();
        chk_out("mr.e1", 12'hABC, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_out("mr.reset", 12'h000, 1'b0, 1'b0);
        chk("mr.ready", 32'(cfg_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk_out("mr.idle", 12'h000, 1'b0, 1'b0);
        div_val = 8'd0; last_idx = 6'd3;
        trig = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            trig = 1'b0;
            chk_out($sformatf("cleared[%0d]", i), 12'h000, 1'b1, 1'b0);
        end
        tick();
        chk_out("cleared.hold", 12'h000, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
